// File: rtl/wsi_pattern_source.sv
// WSI precise-burst message source: incrementing 32-bit data pattern, honours SThreadBusy.
// Run control is strobe/config based; wsi_m_req is fully registered.
module wsi_pattern_source #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             stop,
  input  logic [11:0]      msg_len,
  input  logic [CNT_W-1:0] msg_count,
  input  logic [7:0]       opcode,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             len_err,
  output logic [CNT_W-1:0] msgs_sent,
  output logic [60:0]      wsi_m_req,
  input  logic             wsi_m_SThreadBusy,
  output logic             wsi_m_MReset_n,
  input  logic             wsi_m_SReset_n
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  localparam logic [2:0] MCMD_WRITE = 3'b001;
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [11:0]      len_q, len_d;
  logic [11:0]      widx_q, widx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [7:0]       op_q, op_d;
  logic [31:0]      data_q, data_d;
  logic [7:0]       gap_q, gap_d;
  logic             stop_pend_q, stop_pend_d;
  logic             len_err_q, len_err_d;
  logic [60:0]      req_q, req_d;
  logic             mreset_q;

  logic             issue;
  logic             last_word;
  logic             stop_now;
  logic [CNT_W-1:0] sent_inc;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    widx_d      = widx_q;
    cnt_d       = cnt_q;
    sent_d      = sent_q;
    op_d        = op_q;
    data_d      = data_q;
    gap_d       = gap_q;
    stop_pend_d = stop_pend_q;
    len_err_d   = len_err_q;
    req_d       = '0;

    issue     = (state_q == S_SEND) && !wsi_m_SThreadBusy && wsi_m_SReset_n;
    last_word = (widx_q == len_q);
    // a stop arriving on the deciding edge counts the same as one already pending
    stop_now  = stop_pend_q | stop;
    sent_inc  = sent_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (msg_len != '0) begin
            state_d     = S_SEND;
            len_d       = msg_len;
            cnt_d       = msg_count;
            op_d        = opcode;
            data_d      = seed;
            widx_d      = 12'd1;
            sent_d      = '0;
            stop_pend_d = 1'b0;
            len_err_d   = 1'b0;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (stop) stop_pend_d = 1'b1;
        if (issue) begin
          req_d  = {MCMD_WRITE, last_word, 1'b1, len_q, data_q, 4'hF, op_q};
          data_d = data_q + 32'd1;
          if (last_word) begin
            widx_d = 12'd1;
            sent_d = sent_inc;
            if (stop_now || (cnt_q != '0 && sent_inc == cnt_q)) begin
              state_d     = S_DONE;
              stop_pend_d = 1'b0;
            end else if (GAP_CYCLES != 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end else begin
            widx_d = widx_q + 12'd1;
          end
        end
      end
      S_GAP: begin
        if (stop) stop_pend_d = 1'b1;
        if (gap_q == GAP_LAST) begin
          if (stop_now) begin
            state_d     = S_DONE;
            stop_pend_d = 1'b0;
          end else begin
            state_d = S_SEND;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      widx_q      <= '0;
      cnt_q       <= '0;
      sent_q      <= '0;
      op_q        <= '0;
      data_q      <= '0;
      gap_q       <= '0;
      stop_pend_q <= 1'b0;
      len_err_q   <= 1'b0;
      req_q       <= '0;
      mreset_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      widx_q      <= widx_d;
      cnt_q       <= cnt_d;
      sent_q      <= sent_d;
      op_q        <= op_d;
      data_q      <= data_d;
      gap_q       <= gap_d;
      stop_pend_q <= stop_pend_d;
      len_err_q   <= len_err_d;
      req_q       <= req_d;
      mreset_q    <= 1'b1;
    end
  end

  assign busy           = (state_q == S_SEND) || (state_q == S_GAP);
  assign done           = (state_q == S_DONE);
  assign len_err        = len_err_q;
  assign msgs_sent      = sent_q;
  assign wsi_m_req      = req_q;
  assign wsi_m_MReset_n = mreset_q;

endmodule
